dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the `datamem` data memory. It lets the core load/store unit (port 0, single accesses) and a memory loader/debug engine (port 1, incrementing word bursts) share the single memory port. It does round-robin arbitration, drives `datamem`'s address, data, `funct3` and strobe inputs, and registers read data back to the winning requester. It sits between the requesters and `datamem`; `datamem` is unmodified.

## Interface
- `ADDR_W`, 32: address width
- `DATA_W`, 32: data width
- `LEN_W`, 4: burst length field width; a burst is `m1_len`+1 beats, 1..16
- `clk`  in  1: single clock, all state on rising edge
- `reset`  in  1: asynchronous, active-low reset; clears all state and outputs immediately
- `m0_req`  in  1: port 0 access request
- `m0_we`  in  1: 1 = store, 0 = load
- `m0_addr`  in  ADDR_W: byte address
- `m0_wdata`  in  DATA_W: store data
- `m0_funct3`  in  3: access size/sign, passed through to `datamem`
- `m0_gnt`  out  1: access is being performed this cycle
- `m0_rvalid`  out  1: one-cycle pulse, `m0_rdata` valid
- `m0_rdata`  out  DATA_W: registered load data
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_funct3`: as port 0, but `m1_addr` is the burst base
- `m1_len`  in  LEN_W: beats minus one
- `m1_gnt`  out  1: beat performed this cycle
- `m1_rvalid`  out  1: per-beat read-data pulse
- `m1_rdata`  out  DATA_W: registered per-beat load data
- `m1_done`  out  1: one-cycle pulse the cycle after the final beat
- `mem_addr`  out  ADDR_W: to `datamem`
- `write_data_M`  out  DATA_W: to `datamem`
- `funct3`  out  3: to `datamem`
- `write_en`  out  1: to `datamem`
- `read_en`  out  1: to `datamem`
- `read_data`  in  DATA_W: from `datamem`, combinational on `read_en`/`mem_addr`

## Operation
- FSM states:
  - IDLE: sample `m0_req`/`m1_req`.
  - ACC0: one cycle.
  - BURST1: `m1_len`+1 cycles.
- IDLE transitions:
  - Only `m0_req` high → ACC0.
  - Only `m1_req` high → BURST1.
  - Both high → the port not granted last. Round-robin pointer `last` resets to 1, so port 0 wins the first tie.
- Latching on grant decision:
  - ACC0: latch `m0_we`, `m0_addr`, `m0_funct3` and `m0_wdata`.
  - BURST1: latch `m1_we`, `m1_addr`, `m1_funct3`, `m1_len`; clear beat counter.
- ACC0:
  - `m0_gnt`=1, `mem_addr`=latched addr, `funct3` driven.
  - Store: `write_en`=1, `write_data_M`=latched wdata.
  - Load: `read_en`=1, and `read_data` is captured into `m0_rdata`.
  - Next state IDLE; `last`←0.
- BURST1:
  - Each cycle: `m1_gnt`=1, `mem_addr`=base+4×beat (mod 2^ADDR_W, wraps silently), `funct3`=latched value.
  - Store: `write_data_M`=live `m1_wdata`.
  - Load: `read_data` captured into `m1_rdata`.
  - Beat counter increments each cycle.
  - After beat == len: IDLE, `last`←1, `m1_done` pulses next cycle.
- Burst is never preempted; a port 0 request raised mid-burst waits in IDLE arbitration.
- `req` is sampled only in IDLE. A `req` still high in the IDLE cycle following a grant is a new request, so a requester drops `req` on the edge that ends its final `gnt` cycle.
- Memory outputs in IDLE: all of `write_en`, `read_en`, `mem_addr`, `write_data_M`, `funct3` are 0.
- Reset (any time, including mid-burst):
  - State returns to IDLE and `last`=1.
  - Every output is 0.
  - Beats already written stay in memory; the aborted burst gives no `m1_done`.

## Timing
- Request in IDLE at cycle N → `gnt` and memory strobes in cycle N+1.
- Load data: `rvalid`/`rdata` in the cycle after each access/beat cycle. `rdata` holds until the next load on that port.
- Store data:
  - Port 0 `m0_wdata` is sampled at the grant decision (cycle N).
  - Port 1 `m1_wdata` for beat k must be valid in the k-th `m1_gnt` cycle. The requester advances data on each edge where `m1_gnt`=1.
- Port 1 fields other than `wdata` must be stable from `req` until `m1_done`.
- Throughput:
  - Port 0: one access per 2 cycles.
  - Burst of L+1 beats: L+2 cycles including the return to IDLE.
- `m1_done` coincides with the final `m1_rvalid` for read bursts.
- `m0_gnt` and `m1_gnt` are never high together; `write_en` and `read_en` are never high together.

## Test plan
- Reset, then port 0 store 0xDEADBEEF @0x10 (funct3 010), then load @0x10 → `write_en` for one cycle at N+1; later load gives `m0_rvalid` with `m0_rdata`=0xDEADBEEF.
- Port 1 write burst, base 0x100, len 3, data 1..4, then read burst → `mem_addr` 0x100,0x104,0x108,0x10C; read returns 1,2,3,4 on consecutive `m1_rvalid`; `m1_done` with the 4th.
- Both ports requesting continuously from reset → grants alternate: port 0, port 1 burst, port 0, port 1; no cycle has both `gnt` high.
- Burst base 0xFFFFFFF8, len 3 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- `m0_req` raised in the 2nd beat of a len-7 burst → port 0 granted exactly one cycle after the burst returns to IDLE.
- `reset` low during beat 2 of a len-7 write burst → all outputs 0 immediately; only beats 0–1 are written; no `m1_done`; next tie after reset is won by port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one datamem port between
//            single accesses (port 0) and incrementing word bursts (port 1).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [2:0]        m0_funct3,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [2:0]        m1_funct3,
    input  logic [LEN_W-1:0]  m1_len,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] write_data_M,
    output logic [2:0]        funct3,
    output logic              write_en,
    output logic              read_en,
    input  logic [DATA_W-1:0] read_data
);

    localparam logic [1:0]       c_st_idle   = 2'd0;
    localparam logic [1:0]       c_st_acc0   = 2'd1;
    localparam logic [1:0]       c_st_burst1 = 2'd2;
    localparam logic [LEN_W-1:0] c_beat_one  = LEN_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_funct3;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_beat;
    logic              r_m0_rvalid;
    logic [DATA_W-1:0] r_m0_rdata;
    logic              r_m1_rvalid;
    logic [DATA_W-1:0] r_m1_rdata;
    logic              r_m1_done;

    logic              w_pick0;
    logic              w_pick1;
    logic              w_last_beat;
    logic [ADDR_W-1:0] w_beat_off;
    logic [ADDR_W-1:0] w_beat_addr;

    // On a tie, r_last names the port served most recently; the other one wins.
    assign w_pick0     = m0_req && (!m1_req || r_last);
    assign w_pick1     = m1_req && !w_pick0;
    assign w_last_beat = (r_beat == r_len);
    assign w_beat_off  = {{(ADDR_W-LEN_W-2){1'b0}}, r_beat, 2'b00};
    assign w_beat_addr = r_addr + w_beat_off;

    assign m0_rvalid = r_m0_rvalid;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rvalid = r_m1_rvalid;
    assign m1_rdata  = r_m1_rdata;
    assign m1_done   = r_m1_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_pick0) begin
                    w_state_nxt = c_st_acc0;
                end else if (w_pick1) begin
                    w_state_nxt = c_st_burst1;
                end
            end
            c_st_acc0:   w_state_nxt = c_st_idle;
            c_st_burst1: begin
                if (w_last_beat) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        m0_gnt       = 1'b0;
        m1_gnt       = 1'b0;
        mem_addr     = '0;
        write_data_M = '0;
        funct3       = 3'b000;
        write_en     = 1'b0;
        read_en      = 1'b0;
        case (r_state)
            c_st_acc0: begin
                m0_gnt       = 1'b1;
                mem_addr     = r_addr;
                funct3       = r_funct3;
                write_en     = r_we;
                read_en      = !r_we;
                write_data_M = r_we ? r_wdata : '0;
            end
            c_st_burst1: begin
                // Burst store data is taken live; the requester advances it per beat.
                m1_gnt       = 1'b1;
                mem_addr     = w_beat_addr;
                funct3       = r_funct3;
                write_en     = r_we;
                read_en      = !r_we;
                write_data_M = r_we ? m1_wdata : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last      <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_funct3    <= 3'b000;
            r_len       <= '0;
            r_beat      <= '0;
            r_m0_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rvalid <= 1'b0;
            r_m1_rdata  <= '0;
            r_m1_done   <= 1'b0;
        end else begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m1_done   <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_pick0) begin
                        r_we     <= m0_we;
                        r_addr   <= m0_addr;
                        r_funct3 <= m0_funct3;
                        r_wdata  <= m0_wdata;
                    end else if (w_pick1) begin
                        r_we     <= m1_we;
                        r_addr   <= m1_addr;
                        r_funct3 <= m1_funct3;
                        r_len    <= m1_len;
                        r_beat   <= '0;
                    end
                end
                c_st_acc0: begin
                    r_last <= 1'b0;
                    if (!r_we) begin
                        r_m0_rvalid <= 1'b1;
                        r_m0_rdata  <= read_data;
                    end
                end
                c_st_burst1: begin
                    r_beat <= r_beat + c_beat_one;
                    if (!r_we) begin
                        r_m1_rvalid <= 1'b1;
                        r_m1_rdata  <= read_data;
                    end
                    if (w_last_beat) begin
                        r_last    <= 1'b1;
                        r_m1_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter with a schedule-based model
//            and a word-addressed datamem stand-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [2:0]  m0_funct3 = 3'b000;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [2:0]  m1_funct3 = 3'b000;
    logic [3:0]  m1_len = '0;
    logic        m1_gnt, m1_rvalid, m1_done;
    logic [31:0] m1_rdata;
    logic [31:0] mem_addr, write_data_M, read_data;
    logic [2:0]  funct3;
    logic        write_en, read_en;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_funct3(m0_funct3), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_funct3(m1_funct3), .m1_len(m1_len), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_done(m1_done),
        .mem_addr(mem_addr), .write_data_M(write_data_M), .funct3(funct3),
        .write_en(write_en), .read_en(read_en), .read_data(read_data)
    );

    always #5 clk = ~clk;

    // datamem stand-in: word storage, combinational read
    logic [31:0] dmem    [1024];
    logic [31:0] ref_mem [1024];
    assign read_data = read_en ? dmem[mem_addr[11:2]] : 32'h0;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            dmem[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        forever begin
            @(posedge clk);
            if (write_en) dmem[mem_addr[11:2]] = write_data_M;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: no grant within bound, got 0 expected 1", name);
    endtask

    // ---------------------------------------------------------------- model
    typedef struct {
        bit          g0;
        bit          g1;
        bit          we;
        bit          re;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  f3;
    } acc_t;

    acc_t        sched  [int];
    bit          rv0_c  [int];
    bit          rv1_c  [int];
    bit          done_c [int];
    logic [31:0] exp_rd0 = '0, exp_rd1 = '0;
    bit          last_p = 1'b1;
    int          next_free = 0;
    int          cyc = 0;
    logic [31:0] wbuf [16];
    logic        g1_prev = 1'b0;

    function automatic acc_t zero_acc();
        acc_t z;
        z.g0 = 0; z.g1 = 0; z.we = 0; z.re = 0;
        z.addr = '0; z.wd = '0; z.f3 = '0;
        return z;
    endfunction

    initial begin
        forever begin
            @(negedge reset);
            sched.delete(); rv0_c.delete(); rv1_c.delete(); done_c.delete();
            exp_rd0 = '0; exp_rd1 = '0; last_p = 1'b1; next_free = 0;
        end
    end

    // At each edge: retire the cycle that ends, then plan any grant decided in it.
    initial begin
        acc_t e;
        int   n;
        int   len;
        forever begin
            @(posedge clk);
            n = cyc;
            if (reset) begin
                if (sched.exists(n)) begin
                    e = sched[n];
                    if (e.we) ref_mem[e.addr[11:2]] = e.wd;
                    if (e.re && e.g0) exp_rd0 = ref_mem[e.addr[11:2]];
                    if (e.re && e.g1) exp_rd1 = ref_mem[e.addr[11:2]];
                end
                if (n >= next_free) begin
                    if (m0_req && (!m1_req || last_p)) begin
                        e = zero_acc();
                        e.g0 = 1; e.we = m0_we; e.re = !m0_we;
                        e.addr = m0_addr; e.f3 = m0_funct3;
                        e.wd = m0_we ? m0_wdata : 32'h0;
                        sched[n+1] = e;
                        if (!m0_we) rv0_c[n+2] = 1;
                        next_free = n + 2;
                        last_p = 0;
                    end else if (m1_req) begin
                        len = int'(m1_len);
                        for (int k = 0; k <= len; k++) begin
                            e = zero_acc();
                            e.g1 = 1; e.we = m1_we; e.re = !m1_we;
                            e.addr = m1_addr + 32'(4 * k); e.f3 = m1_funct3;
                            e.wd = m1_we ? wbuf[k] : 32'h0;
                            sched[n+1+k] = e;
                            if (!m1_we) rv1_c[n+2+k] = 1;
                        end
                        done_c[n+2+len] = 1;
                        next_free = n + 2 + len;
                        last_p = 1;
                    end
                end
            end
            cyc = cyc + 1;
        end
    end

    // ---------------------------------------------------------------- compare
    initial begin
        acc_t e;
        forever begin
            @(negedge clk);
            e = sched.exists(cyc) ? sched[cyc] : zero_acc();
            chk1("m0_gnt", m0_gnt, e.g0);
            chk1("m1_gnt", m1_gnt, e.g1);
            chk1("write_en", write_en, e.we);
            chk1("read_en", read_en, e.re);
            chk("mem_addr", mem_addr, e.addr);
            chk("funct3", 32'(funct3), 32'(e.f3));
            if (!sched.exists(cyc) || e.we) chk("write_data_M", write_data_M, e.wd);
            chk1("m0_rvalid", m0_rvalid, rv0_c.exists(cyc));
            chk1("m1_rvalid", m1_rvalid, rv1_c.exists(cyc));
            chk1("m1_done", m1_done, done_c.exists(cyc));
            chk("m0_rdata", m0_rdata, exp_rd0);
            chk("m1_rdata", m1_rdata, exp_rd1);
            chk1("gnt_exclusive", m0_gnt & m1_gnt, 1'b0);
            chk1("strobe_exclusive", write_en & read_en, 1'b0);
            g1_prev = m1_gnt;
        end
    end

    // ---------------------------------------------------------------- stimulus
    int          idx = 0;
    logic [31:0] addr_q [$];
    logic [31:0] rd_q   [$];
    logic        done_seen;

    function automatic logic [31:0] qat(input logic [31:0] q [$], input int k);
        return (k < q.size()) ? q[k] : 32'hBAD0_BAD0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (g1_prev) begin
            idx++;
            if (idx < 16) m1_wdata = wbuf[idx];
        end
    endtask

    task automatic m0_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             output int lat, output logic [31:0] rd, output logic rv,
                             output logic wen_gnt, output logic wen_after);
        bit got = 0;
        m0_we = we; m0_addr = addr; m0_wdata = wd; m0_funct3 = 3'b010; m0_req = 1'b1;
        lat = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (m0_gnt) begin
                got = 1;
                break;
            end
            lat++;
            step();
        end
        if (!got) timeout_fail("m0_access");
        wen_gnt = write_en;
        step();
        m0_req = 1'b0;
        @(negedge clk);
        rv = m0_rvalid; rd = m0_rdata; wen_after = write_en;
        step();
    endtask

    task automatic m1_burst(input logic we, input logic [31:0] base, input int len,
                            input logic [2:0] f3);
        bit got = 0;
        addr_q.delete(); rd_q.delete(); done_seen = 1'b0;
        m1_we = we; m1_addr = base; m1_len = 4'(len); m1_funct3 = f3;
        idx = 0; m1_wdata = wbuf[0]; m1_req = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (m1_gnt) begin
                got = 1;
                break;
            end
            step();
        end
        if (!got) timeout_fail("m1_burst");
        for (int k = 0; k <= len; k++) begin
            if (k > 0) @(negedge clk);
            addr_q.push_back(mem_addr);
            if (m1_rvalid) rd_q.push_back(m1_rdata);
            step();
        end
        m1_req = 1'b0;
        @(negedge clk);
        if (m1_rvalid) rd_q.push_back(m1_rdata);
        done_seen = m1_done;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation bound expired, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        rv, wg, wa, p1;
        int          glog [$];

        for (int k = 0; k < 16; k++) wbuf[k] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_m0_gnt", m0_gnt, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        step();
        reset = 1'b1;
        step();

        // port 0 store then load
        m0_access(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, rv, wg, wa);
        chk("st_latency", 32'(lat), 32'd1);
        chk1("st_wen_at_gnt", wg, 1'b1);
        chk1("st_wen_after", wa, 1'b0);
        chk1("st_no_rvalid", rv, 1'b0);
        m0_access(1'b0, 32'h10, 32'h0, lat, rd, rv, wg, wa);
        chk1("ld_rvalid", rv, 1'b1);
        chk("ld_rdata", rd, 32'hDEADBEEF);
        chk1("ld_no_wen", wg, 1'b0);

        // port 1 write then read burst
        for (int k = 0; k < 4; k++) wbuf[k] = 32'(k + 1);
        m1_burst(1'b1, 32'h100, 3, 3'b010);
        for (int k = 0; k < 4; k++) chk("wb_addr", qat(addr_q, k), 32'h100 + 32'(4 * k));
        m1_burst(1'b0, 32'h100, 3, 3'b010);
        chk("rb_count", 32'(rd_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk("rb_data", qat(rd_q, k), 32'(k + 1));
        chk1("rb_done_with_last", done_seen, 1'b1);

        // address wrap
        m1_burst(1'b0, 32'hFFFF_FFF8, 3, 3'b100);
        chk("wrap_a0", qat(addr_q, 0), 32'hFFFF_FFF8);
        chk("wrap_a1", qat(addr_q, 1), 32'hFFFF_FFFC);
        chk("wrap_a2", qat(addr_q, 2), 32'h0000_0000);
        chk("wrap_a3", qat(addr_q, 3), 32'h0000_0004);

        // port 0 raised during beat 1 of a len-7 read burst
        m1_we = 1'b0; m1_addr = 32'h300; m1_len = 4'd7; m1_funct3 = 3'b010; m1_req = 1'b1;
        step();
        step();
        m0_we = 1'b0; m0_addr = 32'h10; m0_funct3 = 3'b010; m0_req = 1'b1;
        repeat (6) step();
        @(negedge clk);
        chk1("mid_last_beat", m1_gnt, 1'b1);
        step();
        m1_req = 1'b0;
        @(negedge clk);
        chk1("mid_done", m1_done, 1'b1);
        chk1("mid_g0_waits", m0_gnt, 1'b0);
        step();
        @(negedge clk);
        chk1("mid_g0_granted", m0_gnt, 1'b1);
        step();
        m0_req = 1'b0;
        step();

        // reset during beat 2 of a len-7 write burst
        for (int k = 0; k < 8; k++) wbuf[k] = 32'hA0 + 32'(k);
        m1_we = 1'b1; m1_addr = 32'h200; m1_len = 4'd7; m1_funct3 = 3'b010;
        idx = 0; m1_wdata = wbuf[0]; m1_req = 1'b1;
        step();
        step();
        step();
        #1 reset = 1'b0;
        #1;
        chk1("abort_m1_gnt", m1_gnt, 1'b0);
        chk1("abort_write_en", write_en, 1'b0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk("abort_wdata", write_data_M, 32'h0);
        chk("abort_m1_rdata", m1_rdata, 32'h0);
        chk("abort_m0_rdata", m0_rdata, 32'h0);
        m1_req = 1'b0;
        step();
        step();
        reset = 1'b1;
        chk("abort_mem0", dmem[10'h080], 32'hA0);
        chk("abort_mem1", dmem[10'h081], 32'hA1);
        chk("abort_mem2", dmem[10'h082], 32'h0);
        chk("abort_mem7", dmem[10'h087], 32'h0);

        // first tie after reset goes to port 0
        m0_we = 1'b0; m0_addr = 32'h200; m0_req = 1'b1;
        m1_we = 1'b0; m1_addr = 32'h204; m1_len = 4'd0; m1_req = 1'b1;
        step();
        @(negedge clk);
        chk1("tie_m0", m0_gnt, 1'b1);
        chk1("tie_m1", m1_gnt, 1'b0);
        step();
        m0_req = 1'b0;
        step();
        step();
        m1_req = 1'b0;
        step();
        step();

        // both ports requesting continuously from reset
        reset = 1'b0;
        m0_we = 1'b0; m0_addr = 32'h10; m0_funct3 = 3'b010; m0_req = 1'b1;
        m1_we = 1'b0; m1_addr = 32'h100; m1_len = 4'd1; m1_funct3 = 3'b010; m1_req = 1'b1;
        step();
        step();
        reset = 1'b1;
        p1 = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (m0_gnt) glog.push_back(0);
            if (m1_gnt && !p1) glog.push_back(1);
            p1 = m1_gnt;
            step();
        end
        chk("alt_count_ge4", 32'(glog.size() >= 4), 32'd1);
        for (int k = 0; k < 4; k++)
            chk("alt_order", (k < glog.size()) ? 32'(glog[k]) : 32'hFF, 32'(k % 2));
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
